// File: rtl/i2s_frame_fifo_pkg.sv
// Shared DAQ definitions: sample/word/frame widths, pairing states, sample extension.
package i2s_frame_fifo_pkg;

    localparam int SAMPLE_W = 24;
    localparam int WORD_W   = 32;
    localparam int FRAME_W  = 64;

    typedef enum logic {
        WAIT_L = 1'b0,
        WAIT_R = 1'b1
    } pair_state_t;

    function automatic logic [WORD_W-1:0] ext_sample(input logic [SAMPLE_W-1:0] s,
                                                     input logic               sign_ext);
        if (sign_ext)
            return {{(WORD_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
        else
            return {{(WORD_W-SAMPLE_W){1'b0}}, s};
    endfunction

endpackage

// File: rtl/i2s_frame_fifo_sync_fifo.sv
// Generic register-array FIFO, first-word-fall-through: write visible on rd_dat the cycle after.
// Latency 1 cycle write-to-read; accepts a write when full only if a read happens the same cycle.
// Backpressure: rd_rdy stalls the head; writes beyond capacity are ignored (caller checks full).
module sync_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_fire;
    logic          rd_fire;

    assign empty   = (fill == '0);
    assign full    = (fill == FULL_CNT);
    assign rd_vld  = !empty;
    assign rd_dat  = mem[rd_ptr];
    assign rd_fire = rd_rdy && !empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign wr_fire = wr_vld && (!full || rd_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (wr_fire) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_fire)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_fire, rd_fire})
                2'b10:   fill <= fill + (AW+1)'(1);
                2'b01:   fill <= fill - (AW+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/i2s_frame_fifo.sv
// Pairs i2s left/right samples into 64-bit stereo frames and buffers them for the DMA packer.
// Latency: frame visible on m_data/m_valid the cycle after its right sample strobe.
// Backpressure: m_ready stalls the FIFO; frames arriving while full are dropped and flag ovf.
module i2s_frame_fifo
    import i2s_frame_fifo_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int SIGN_EXT = 1
) (
    input  logic                      AMSCK,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [SAMPLE_W-1:0]       din,
    input  logic                      valid_l,
    input  logic                      valid_r,
    output logic [FRAME_W-1:0]        m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [$clog2(DEPTH):0]    fill,
    output logic                      ovf,
    input  logic                      ovf_clr
);

    localparam logic SEXT = (SIGN_EXT != 0);

    pair_state_t         state;
    pair_state_t         state_nxt;
    logic [SAMPLE_W-1:0] l_hold;
    logic                l_load;
    logic                frame_req;
    logic [FRAME_W-1:0]  frame_dat;
    logic                fifo_full;
    logic                fifo_empty;
    logic                wr_ok;

    always_ff @(posedge AMSCK or negedge rst_n) begin
        if (!rst_n) state <= WAIT_L;
        else        state <= state_nxt;
    end

    // valid_l wins over a simultaneous valid_r, so the right strobe only counts alone.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = WAIT_L;
        end else begin
            case (state)
                WAIT_L:  if (valid_l) state_nxt = WAIT_R;
                WAIT_R:  if (!valid_l && valid_r) state_nxt = WAIT_L;
                default: state_nxt = WAIT_L;
            endcase
        end
    end

    always_comb begin
        l_load    = en && valid_l;
        frame_req = en && (state == WAIT_R) && valid_r && !valid_l;
    end

    always_ff @(posedge AMSCK or negedge rst_n) begin
        if (!rst_n)      l_hold <= '0;
        else if (l_load) l_hold <= din;
    end

    assign frame_dat = {ext_sample(din, SEXT), ext_sample(l_hold, SEXT)};
    assign wr_ok     = !fifo_full || (m_valid && m_ready);

    always_ff @(posedge AMSCK or negedge rst_n) begin
        if (!rst_n)                   ovf <= 1'b0;
        else if (frame_req && !wr_ok) ovf <= 1'b1;
        else if (ovf_clr)             ovf <= 1'b0;
    end

    sync_fifo #(
        .W     (FRAME_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (AMSCK),
        .rst_n  (rst_n),
        .wr_vld (frame_req),
        .wr_dat (frame_dat),
        .rd_rdy (m_ready),
        .rd_vld (m_valid),
        .rd_dat (m_data),
        .fill   (fill),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // fifo_empty mirrors !m_valid; kept as an explicit cross-check of the FIFO outputs.
    always_ff @(posedge AMSCK) begin
        assert (fifo_empty == !m_valid);
    end

endmodule

// File: tb/tb_i2s_frame_fifo.sv
// Directed bench: two instances (sign- and zero-extending) share all inputs.
module tb_i2s_frame_fifo;

    logic        AMSCK = 1'b0;
    logic        rst_n;
    logic        en;
    logic [23:0] din;
    logic        valid_l;
    logic        valid_r;
    logic        m_ready;
    logic        ovf_clr;

    logic [63:0] se_data,  ze_data;
    logic        se_valid, ze_valid;
    logic [4:0]  se_fill,  ze_fill;
    logic        se_ovf,   ze_ovf;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 AMSCK = ~AMSCK;

    i2s_frame_fifo #(.DEPTH(16), .SIGN_EXT(1)) u_se (
        .AMSCK(AMSCK), .rst_n(rst_n), .en(en), .din(din),
        .valid_l(valid_l), .valid_r(valid_r),
        .m_data(se_data), .m_valid(se_valid), .m_ready(m_ready),
        .fill(se_fill), .ovf(se_ovf), .ovf_clr(ovf_clr)
    );

    i2s_frame_fifo #(.DEPTH(16), .SIGN_EXT(0)) u_ze (
        .AMSCK(AMSCK), .rst_n(rst_n), .en(en), .din(din),
        .valid_l(valid_l), .valid_r(valid_r),
        .m_data(ze_data), .m_valid(ze_valid), .m_ready(m_ready),
        .fill(ze_fill), .ovf(ze_ovf), .ovf_clr(ovf_clr)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, act, exp);
    endtask

    // One-cycle strobe of a left (is_l=1) or right sample, returning on the following negedge.
    task automatic send(input logic is_l, input logic [23:0] d);
        @(negedge AMSCK);
        din     = d;
        valid_l = is_l;
        valid_r = !is_l;
        @(negedge AMSCK);
        valid_l = 1'b0;
        valid_r = 1'b0;
    endtask

    task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
        send(1'b1, l);
        send(1'b0, r);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; din = '0; valid_l = 0; valid_r = 0;
        m_ready = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(negedge AMSCK);
        chk("rst_valid", 64'(se_valid), 64'd0);
        chk("rst_fill",  64'(se_fill),  64'd0);
        chk("rst_ovf",   64'(se_ovf),   64'd0);
        chk("rst_data",  se_data,       64'd0);
        rst_n = 1'b1;

        // Basic pair, consumer always ready
        m_ready = 1'b1;
        send(1'b1, 24'h885511);
        chk("basic_no_early_valid", 64'(se_valid), 64'd0);
        send(1'b0, 24'h123456);
        chk("basic_valid", 64'(se_valid), 64'd1);
        chk("basic_fill1", 64'(se_fill),  64'd1);
        chk("basic_se",    se_data, 64'h00123456_FF885511);
        chk("basic_ze",    ze_data, 64'h00123456_00885511);
        @(negedge AMSCK);
        chk("basic_fill0",  64'(se_fill),  64'd0);
        chk("basic_drained", 64'(se_valid), 64'd0);

        // Zero-extend positive samples
        m_ready = 1'b0;
        send_pair(24'h654321, 24'h40724F);
        chk("ze_pos", ze_data, 64'h0040724F_00654321);
        chk("se_pos", se_data, 64'h0040724F_00654321);
        m_ready = 1'b1;
        @(negedge AMSCK);
        m_ready = 1'b0;
        chk("ze_pos_fill0", 64'(ze_fill), 64'd0);

        // Orphan right then left resync
        send(1'b0, 24'h111111);
        chk("orphan_fill", 64'(se_fill), 64'd0);
        send(1'b1, 24'hAAAAAA);
        send(1'b1, 24'h654321);
        send(1'b0, 24'h40724F);
        @(negedge AMSCK);
        chk("resync_fill", 64'(ze_fill), 64'd1);
        chk("resync_data", ze_data, 64'h0040724F_00654321);
        m_ready = 1'b1;
        @(negedge AMSCK);
        m_ready = 1'b0;
        chk("resync_one_frame", 64'(ze_fill), 64'd0);

        // en dropped between left and right discards the half frame
        send(1'b1, 24'h000005);
        @(negedge AMSCK); en = 1'b0;
        @(negedge AMSCK); en = 1'b1;
        send(1'b0, 24'h000006);
        chk("en_discard", 64'(se_fill), 64'd0);

        // Overflow: 17 pairs into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            send_pair(24'(i), 24'(i + 100));
            if (i == 15) chk("ovf_full_no_flag", 64'(se_ovf), 64'd0);
        end
        chk("ovf_fill", 64'(se_fill), 64'd16);
        chk("ovf_set",  64'(se_ovf),  64'd1);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovf_drain%0d", i), se_data, {32'(i + 100), 32'(i)});
            @(negedge AMSCK);
        end
        m_ready = 1'b0;
        chk("ovf_drained", 64'(se_fill), 64'd0);
        chk("ovf_sticky",  64'(se_ovf),  64'd1);
        ovf_clr = 1'b1;
        @(negedge AMSCK);
        ovf_clr = 1'b0;
        chk("ovf_clr", 64'(se_ovf), 64'd0);

        // Full with a same-cycle read: write accepted
        for (int i = 0; i < 16; i++) send_pair(24'(i), 24'(i + 100));
        send(1'b1, 24'd16);
        @(negedge AMSCK);
        din = 24'd116; valid_r = 1'b1; m_ready = 1'b1;
        @(negedge AMSCK);
        valid_r = 1'b0; m_ready = 1'b0;
        chk("full_rw_fill", 64'(se_fill), 64'd16);
        chk("full_rw_ovf",  64'(se_ovf),  64'd0);
        m_ready = 1'b1;
        for (int i = 1; i < 17; i++) begin
            chk($sformatf("full_rw_drain%0d", i), se_data, {32'(i + 100), 32'(i)});
            @(negedge AMSCK);
        end
        m_ready = 1'b0;
        chk("full_rw_empty", 64'(se_valid), 64'd0);

        // Mid-operation reset
        for (int i = 0; i < 3; i++) send_pair(24'(i + 1), 24'(i + 2));
        send(1'b1, 24'h000777);
        chk("pre_rst_fill", 64'(se_fill), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(se_valid), 64'd0);
        chk("mid_rst_fill",  64'(se_fill),  64'd0);
        chk("mid_rst_data",  se_data,       64'd0);
        @(negedge AMSCK);
        rst_n = 1'b1;
        send(1'b0, 24'h000888);
        chk("post_rst_lone_r", 64'(se_fill), 64'd0);
        send_pair(24'hFFFFFF, 24'h800000);
        chk("post_rst_pair_se", se_data, 64'hFF800000_FFFFFFFF);
        chk("post_rst_pair_ze", ze_data, 64'h00800000_00FFFFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
